ram_mbist_ctrl: RTL and testbench



---
 rtl/ram_mbist_pkg.sv | 31 +++
 rtl/ram_mbist_ctrl_if.sv | 33 +++
 rtl/mbist_march_seq.sv | 69 ++++++
 rtl/ram_mbist_ctrl.sv | 153 +++++++++++++++
 tb/tb_ram_mbist_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_mbist_pkg.sv
// Shared definitions for the RAM march BIST controller.
//   - FSM state encoding (exposed on the controller's fsm_state debug port)
//   - march element count
//   - per-element direction, op count and data-background constants for
//     March C-, as bit maps indexed by element number (bits 6/7 unused)
package ram_mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_ELEM = 6;

  // Element sequence:
  //   e0 up w0 | e1 up r0,w1 | e2 up r1,w0 | e3 down r0,w1 | e4 down r1,w0 | e5 up r0

  // Address direction: 1 = descending.
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  // Elements with two operations per address (read then write).
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  // First operation is a write (only e0); otherwise it is a read.
  // The second operation, where present, is always a write.
  localparam logic [7:0] OP0_WRITE    = 8'b0000_0001;
  // Data background for the first and second operation: 1 = all ones.
  localparam logic [7:0] OP0_ONES     = 8'b0001_0100;
  localparam logic [7:0] OP1_ONES     = 8'b0000_1010;

endpackage

// File: rtl/ram_mbist_ctrl_if.sv
// RAM-side bus of the BIST controller: functional requests in, RAM controls
// out, RAM read data back.
//   master : the controller (consumes func_* and mem_DOUT, drives mem_*)
//   slave  : the system side (drives func_* and mem_DOUT, observes mem_*)
// Control encoding on both func_* and mem_* (Read/Write):
//   1/1 = write mem_DIN to mem_ADDR at the clock edge
//   0/0 = read; mem_DOUT reflects mem_ADDR
//   1/0 = idle
// There is no ready/backpressure: every operation completes in one cycle.
interface ram_mbist_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              func_Read;
  logic              func_Write;
  logic [ADDR_W-1:0] func_ADDR;
  logic [DATA_W-1:0] func_DIN;
  logic              mem_Read;
  logic              mem_Write;
  logic [ADDR_W-1:0] mem_ADDR;
  logic [DATA_W-1:0] mem_DIN;
  logic [DATA_W-1:0] mem_DOUT;

  modport master (
    input  func_Read, func_Write, func_ADDR, func_DIN, mem_DOUT,
    output mem_Read, mem_Write, mem_ADDR, mem_DIN
  );

  modport slave (
    output func_Read, func_Write, func_ADDR, func_DIN, mem_DOUT,
    input  mem_Read, mem_Write, mem_ADDR, mem_DIN
  );
endinterface

// File: rtl/mbist_march_seq.sv
// March C- sequence generator.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart at element 0, address sweep 0, first op
//   advance    : step to the next operation
//   addr       : address of the current operation
//   elem       : current march element (0..5)
//   is_write   : current operation writes (else reads and compares)
//   data       : write data, or expected read data
//   last       : current operation is the final one of the test
module mbist_march_seq
  import ram_mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        elem,
  output logic              is_write,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // The sweep counter always counts upward and simply wraps between
  // elements; descending elements use its complement as the address.
  logic [ADDR_W-1:0] sweep;
  logic              op_idx;
  logic              last_op;
  logic              last_addr;
  logic              last_elem;
  logic              ones;

  always_comb begin
    last_op   = op_idx || !ELEM_TWO_OPS[elem];
    last_addr = &sweep;
    last_elem = (elem == 3'(NUM_ELEM - 1));
    last      = last_op && last_addr && last_elem;
    addr      = ELEM_DOWN[elem] ? ~sweep : sweep;
    is_write  = op_idx | OP0_WRITE[elem];
    ones      = op_idx ? OP1_ONES[elem] : OP0_ONES[elem];
    data      = {DATA_W{ones}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep  <= '0;
      op_idx <= 1'b0;
      elem   <= '0;
    end else if (clear) begin
      sweep  <= '0;
      op_idx <= 1'b0;
      elem   <= '0;
    end else if (advance) begin
      if (!last_op) begin
        op_idx <= 1'b1;
      end else begin
        op_idx <= 1'b0;
        sweep  <= sweep + ADDR_W'(1);
        if (last_addr) begin
          elem <= last_elem ? 3'd0 : elem + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_mbist_ctrl.sv
// March C- memory BIST controller with functional passthrough.
//   CoreIN_CLK, CoreIN_RESET : clock, async active-low reset
//   BIST_START               : test request, sampled in IDLE
//   bus                      : functional request / RAM bus (master side)
//   BIST_BUSY, BIST_DONE     : test running / test finished, results valid
//   BIST_FAIL, FAIL_*        : sticky fail flag and first-mismatch record
//   FAIL_CNT                 : mismatch count, saturating at 255
//   fsm_state                : current controller state (debug)
// Each march operation takes two cycles: SETUP presents address/data with
// idle controls, STROBE applies the operation; reads are compared at the
// edge that ends STROBE.
module ram_mbist_ctrl
  import ram_mbist_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 CoreIN_CLK,
  input  logic                 CoreIN_RESET,
  input  logic                 BIST_START,
  ram_mbist_ctrl_if.master     bus,
  output logic                 BIST_BUSY,
  output logic                 BIST_DONE,
  output logic                 BIST_FAIL,
  output logic [ADDR_W-1:0]    FAIL_ADDR,
  output logic [2:0]           FAIL_ELEM,
  output logic [DATA_W-1:0]    FAIL_EXP,
  output logic [7:0]           FAIL_CNT,
  output state_t               fsm_state
);

  state_t              state;
  state_t              state_next;
  logic                start_test;
  logic                seq_adv;
  logic                mismatch;
  logic [ADDR_W-1:0]   seq_addr;
  logic [2:0]          seq_elem;
  logic                seq_is_write;
  logic [DATA_W-1:0]   seq_data;
  logic                seq_last;
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;

  mbist_march_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk      (CoreIN_CLK),
    .rst_n    (CoreIN_RESET),
    .clear    (start_test),
    .advance  (seq_adv),
    .addr     (seq_addr),
    .elem     (seq_elem),
    .is_write (seq_is_write),
    .data     (seq_data),
    .last     (seq_last)
  );

  assign mismatch = (state == ST_STROBE) && !seq_is_write && (bus.mem_DOUT != seq_data);

  always_ff @(posedge CoreIN_CLK or negedge CoreIN_RESET) begin
    if (!CoreIN_RESET) state <= ST_IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_test = 1'b0;
    seq_adv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (BIST_START) begin
          state_next = ST_SETUP;
          start_test = 1'b1;
        end
      end
      ST_SETUP: state_next = ST_STROBE;
      ST_STROBE: begin
        seq_adv = 1'b1;
        if (seq_last || ((STOP_ON_FAIL != 0) && mismatch)) state_next = ST_DONE;
        else                                               state_next = ST_SETUP;
      end
      ST_DONE: begin
        // Leaving DONE needs BIST_START low, so a held request cannot rerun.
        if (!BIST_START) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result registers: cleared when a test launches, held otherwise.
  always_ff @(posedge CoreIN_CLK or negedge CoreIN_RESET) begin
    if (!CoreIN_RESET) begin
      BIST_DONE <= 1'b0;
      BIST_FAIL <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_EXP  <= '0;
      FAIL_CNT  <= '0;
    end else if (start_test) begin
      BIST_DONE <= 1'b0;
      BIST_FAIL <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_EXP  <= '0;
      FAIL_CNT  <= '0;
    end else begin
      if (mismatch) begin
        if (!BIST_FAIL) begin
          FAIL_ADDR <= seq_addr;
          FAIL_ELEM <= seq_elem;
          FAIL_EXP  <= seq_data;
        end
        BIST_FAIL <= 1'b1;
        if (FAIL_CNT != 8'hFF) FAIL_CNT <= FAIL_CNT + 8'd1;
      end
      if ((state == ST_STROBE) && (state_next == ST_DONE)) BIST_DONE <= 1'b1;
    end
  end

  // Output mux: functional passthrough whenever no test is running; since
  // state resets asynchronously, passthrough returns immediately on reset.
  always_comb begin
    BIST_BUSY = (state == ST_SETUP) || (state == ST_STROBE);
    mem_read  = bus.func_Read;
    mem_write = bus.func_Write;
    mem_addr  = bus.func_ADDR;
    mem_din   = bus.func_DIN;
    if (BIST_BUSY) begin
      mem_addr = seq_addr;
      mem_din  = seq_data;
      if (state == ST_SETUP) begin
        mem_read  = 1'b1;
        mem_write = 1'b0;
      end else begin
        // write = 1/1, read = 0/0
        mem_read  = seq_is_write;
        mem_write = seq_is_write;
      end
    end
  end

  assign bus.mem_Read  = mem_read;
  assign bus.mem_Write = mem_write;
  assign bus.mem_ADDR  = mem_addr;
  assign bus.mem_DIN   = mem_din;
  assign fsm_state     = state;

endmodule

// File: tb/tb_ram_mbist_ctrl.sv
`timescale 1ns/1ps
module tb_ram_mbist_ctrl;
  import ram_mbist_pkg::*;

  localparam int AW        = 6;
  localparam int DW        = 8;
  localparam int NW        = 64;
  localparam int TOTAL_CYC = 1280;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  logic          f_read  = 1'b1;
  logic          f_write = 1'b0;
  logic [AW-1:0] f_addr  = '0;
  logic [DW-1:0] f_din   = '0;
  bit            fault_en = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int run_base = 0;
  int runs_started = 0;
  int runs_aborted = 0;
  int runs_checked = 0;

  // ---------------- DUTs and RAM models ----------------
  ram_mbist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ram_mbist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.func_Read = f_read;  assign bus1.func_Read = f_read;
  assign bus0.func_Write = f_write; assign bus1.func_Write = f_write;
  assign bus0.func_ADDR = f_addr;  assign bus1.func_ADDR = f_addr;
  assign bus0.func_DIN = f_din;    assign bus1.func_DIN = f_din;

  logic [DW-1:0] ram0 [NW];
  logic [DW-1:0] ram1 [NW];
  always @(posedge clk) if (bus0.mem_Read && bus0.mem_Write) ram0[bus0.mem_ADDR] <= bus0.mem_DIN;
  always @(posedge clk) if (bus1.mem_Read && bus1.mem_Write) ram1[bus1.mem_ADDR] <= bus1.mem_DIN;
  // Optional bit0 stuck-at-1 cell at 0x2A.
  assign bus0.mem_DOUT = ram0[bus0.mem_ADDR] | ((fault_en && bus0.mem_ADDR == 6'h2A) ? 8'h01 : 8'h00);
  assign bus1.mem_DOUT = ram1[bus1.mem_ADDR] | ((fault_en && bus1.mem_ADDR == 6'h2A) ? 8'h01 : 8'h00);

  logic          busy0, done0, fail0, busy1, done1, fail1;
  logic [AW-1:0] faddr0, faddr1;
  logic [2:0]    felem0, felem1;
  logic [DW-1:0] fexp0, fexp1;
  logic [7:0]    fcnt0, fcnt1;
  state_t        st0, st1;

  ram_mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(0)) dut (
    .CoreIN_CLK(clk), .CoreIN_RESET(rst_n), .BIST_START(start), .bus(bus0),
    .BIST_BUSY(busy0), .BIST_DONE(done0), .BIST_FAIL(fail0), .FAIL_ADDR(faddr0),
    .FAIL_ELEM(felem0), .FAIL_EXP(fexp0), .FAIL_CNT(fcnt0), .fsm_state(st0)
  );

  ram_mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(1)) dut_sof (
    .CoreIN_CLK(clk), .CoreIN_RESET(rst_n), .BIST_START(start), .bus(bus1),
    .BIST_BUSY(busy1), .BIST_DONE(done1), .BIST_FAIL(fail1), .FAIL_ADDR(faddr1),
    .FAIL_ELEM(felem1), .FAIL_EXP(fexp1), .FAIL_CNT(fcnt1), .fsm_state(st1)
  );

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Flat list of every march operation in execution order; operation j is
  // in SETUP during cycle 2j and in STROBE during cycle 2j+1 after launch.
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            elem;
  } op_t;
  op_t ops[$];

  int            m_cnt;
  int            m_first;
  int            sof_end;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_elem;
  logic [DW-1:0] m_exp;

  task automatic build_ops();
    int n_of [6]    = '{1, 2, 2, 2, 2, 1};
    bit down_of [6] = '{0, 0, 0, 1, 1, 0};
    bit wr_of [6][2]  = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit one_of [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    ops.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < NW; i++)
        for (int k = 0; k < n_of[e]; k++) begin
          op_t o;
          o.wr   = wr_of[e][k];
          o.addr = AW'(down_of[e] ? NW - 1 - i : i);
          o.data = one_of[e][k] ? 8'hFF : 8'h00;
          o.elem = e;
          ops.push_back(o);
        end
  endtask

  // Replays the operation list against a plain array RAM with the optional
  // fault and records what the results must be.
  task automatic compute_model(input bit fault);
    logic [DW-1:0] mram [NW];
    logic [DW-1:0] rd;
    m_cnt = 0; m_first = -1; m_addr = '0; m_elem = '0; m_exp = '0;
    foreach (mram[i]) mram[i] = '0;
    for (int j = 0; j < ops.size(); j++) begin
      if (ops[j].wr) mram[ops[j].addr] = ops[j].data;
      else begin
        rd = mram[ops[j].addr] | ((fault && ops[j].addr == 6'h2A) ? 8'h01 : 8'h00);
        if (rd != ops[j].data) begin
          if (m_first < 0) begin
            m_first = j; m_addr = ops[j].addr; m_elem = 3'(ops[j].elem); m_exp = ops[j].data;
          end
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    sof_end = (m_first >= 0) ? 2 * m_first + 2 : TOTAL_CYC;
  endtask

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (runs_started - runs_aborted > runs_checked) begin
      int c;
      op_t o;
      c = cycle_n - run_base;
      if (c >= 0 && c < TOTAL_CYC) begin
        o = ops[c / 2];
        chk("busy", busy0, 1);
        chk("done_early", done0, 0);
        chk("mem_addr", bus0.mem_ADDR, o.addr);
        if (c % 2 == 0) begin
          chk("setup_rd", bus0.mem_Read, 1);
          chk("setup_wr", bus0.mem_Write, 0);
        end else begin
          chk("strobe_rd", bus0.mem_Read, o.wr);
          chk("strobe_wr", bus0.mem_Write, o.wr);
        end
        if (o.wr) chk("mem_din", bus0.mem_DIN, o.data);
        if (c == 0) begin
          chk("clr_fail", fail0, 0);
          chk("clr_cnt", fcnt0, 0);
        end
        chk("sof_busy", busy1, c < sof_end);
        chk("sof_done", done1, c >= sof_end);
      end else if (c == TOTAL_CYC) begin
        chk("end_busy", busy0, 0);
        chk("end_done", done0, 1);
        chk("end_state", st0, ST_DONE);
        chk("end_fail", fail0, m_cnt != 0);
        chk("end_cnt", fcnt0, m_cnt);
        chk("end_faddr", faddr0, m_addr);
        chk("end_felem", felem0, m_elem);
        chk("end_fexp", fexp0, m_exp);
        chk("sof_end_done", done1, 1);
        chk("sof_end_busy", busy1, 0);
        chk("sof_end_cnt", fcnt1, (m_first >= 0) ? 1 : 0);
        chk("sof_end_faddr", faddr1, m_addr);
        runs_checked++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wiggle();
    f_read  = 1'($urandom_range(0, 1));
    f_write = 1'($urandom_range(0, 1));
    f_addr  = AW'($urandom_range(0, NW - 1));
    f_din   = DW'($urandom_range(0, 255));
  endtask

  task automatic quiet();
    f_read = 1'b1; f_write = 1'b0;
  endtask

  task automatic launch(input bit fault, input bit hold);
    @(negedge clk);
    fault_en = fault;
    compute_model(fault);
    start = 1'b1;
    run_base = cycle_n + 1;
    runs_started++;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_run();
    int target;
    target = runs_started - runs_aborted;
    for (int i = 0; i < TOTAL_CYC + 200 && runs_checked < target; i++) begin
      @(negedge clk);
      wiggle();
    end
    quiet();
    chk("run_timeout", runs_checked >= target, 1);
  endtask

  task automatic idle_access(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    f_read = 1'b1; f_write = 1'b1; f_addr = a; f_din = d;
    #1;
    chk("pass_rd", bus0.mem_Read, 1);
    chk("pass_wr", bus0.mem_Write, 1);
    chk("pass_addr", bus0.mem_ADDR, a);
    chk("pass_din", bus1.mem_DIN, d);
    @(negedge clk);
    f_read = 1'b0; f_write = 1'b0;
    #1;
    chk("func_rd0", bus0.mem_DOUT, d);
    chk("func_rd1", bus1.mem_DOUT, d);
    @(negedge clk);
    quiet();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_ops();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_cnt", fcnt0, 0);
    chk("rst_state", st0, ST_IDLE);
    chk("rst_sof_state", st1, ST_IDLE);
    rst_n = 1'b1;

    // Pin the model with hand-derived values.
    chk("model_ops", ops.size(), 640);
    chk("model_op148_addr", ops[148].addr, 6'h2A);
    chk("model_op148_elem", ops[148].elem, 1);
    chk("model_op148_rd", ops[148].wr, 0);
    compute_model(1'b1);
    chk("model_fault_cnt", m_cnt, 3);
    chk("model_fault_first", m_first, 148);
    chk("model_sof_end", sof_end, 298);

    // Functional passthrough in IDLE.
    idle_access(6'h10, 8'h5A);
    for (int i = 0; i < 6; i++)
      idle_access(AW'($urandom_range(0, NW - 1)), DW'($urandom_range(0, 255)));

    // Fault-free run.
    launch(1'b0, 1'b0);
    wait_run();

    // Stuck-at-1 bit0 at 0x2A.
    launch(1'b1, 1'b0);
    wait_run();
    chk("f45_addr", faddr0, 6'h2A);
    chk("f45_elem", felem0, 1);
    chk("f45_exp", fexp0, 8'h00);
    chk("f45_cnt", fcnt0, 3);
    chk("f46_cnt", fcnt1, 1);
    chk("f46_addr", faddr1, 6'h2A);
    chk("f46_done", done1, 1);

    // Reset 500 cycles into a failing test.
    launch(1'b1, 1'b0);
    repeat (500) begin
      @(negedge clk);
      wiggle();
    end
    chk("pre_rst_fail", fail0, 1);
    #3;
    runs_aborted++;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy0, 0);
    chk("ar_done", done0, 0);
    chk("ar_fail", fail0, 0);
    chk("ar_faddr", faddr0, 0);
    chk("ar_felem", felem0, 0);
    chk("ar_fexp", fexp0, 0);
    chk("ar_cnt", fcnt0, 0);
    chk("ar_state", st0, ST_IDLE);
    chk("ar_sof_done", done1, 0);
    chk("ar_sof_fail", fail1, 0);
    chk("ar_pass_addr", bus0.mem_ADDR, f_addr);
    chk("ar_pass_din", bus0.mem_DIN, f_din);
    chk("ar_pass_rd", bus0.mem_Read, f_read);
    chk("ar_pass_wr", bus0.mem_Write, f_write);
    @(negedge clk);
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 1'b0);
    wait_run();

    // BIST_START held high through DONE.
    launch(1'b1, 1'b1);
    wait_run();
    repeat (20) @(negedge clk);
    chk("hold_state", st0, ST_DONE);
    chk("hold_busy", busy0, 0);
    chk("hold_done", done0, 1);
    chk("hold_fail", fail0, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_state", st0, ST_IDLE);
    chk("drop_done_held", done0, 1);
    chk("drop_cnt_held", fcnt0, 3);
    launch(1'b0, 1'b0);
    wait_run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
